// File: rtl/fxp_led_bar_meter.sv
// fxp_led_bar_meter
//   Display stage between the fixed-point DSP output and the board LEDs.
//   Each accepted signed sample becomes a saturated magnitude. A peak level
//   is then tracked with hold/decay timing and drives a thermometer LED bar.
//
//   Pipeline (edge that accepts the sample = A):
//     A   : mag register loads |i_data| (most-negative saturates to max)
//     A+1 : o_level updates
//     A+2 : o_led updates from o_level
//
//   Build option FXP_LED_PEAK_HOLD_EN:
//     defined   -> peak FSM (TRACK/HOLD/DECAY) with hold and decay counters
//     undefined -> o_level simply follows the last accepted magnitude
//
//   o_state is a debug view of the peak FSM: 0=TRACK, 1=HOLD, 2=DECAY
//   (constant 0 when the peak-hold logic is not built).
//
//   Handshake: a sample transfers on any edge where i_valid && o_ready.
//   o_ready is low only in reset and from the first edge after reset is
//   released it stays high, so one sample per cycle is always accepted.
module fxp_led_bar_meter #(
   parameter int DATA_W       = 8,
   parameter int LED_W        = 6,
   parameter int HOLD_CYCLES  = 2700000,
   parameter int DECAY_CYCLES = 270000,
   parameter int DECAY_STEP   = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic [DATA_W-2:0] o_level,
   output logic [LED_W-1:0]  o_led,
   output logic [1:0]        o_state
);

   localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   logic              ready_q;
   logic              accept;
   logic [DATA_W-1:0] neg_data;
   logic [DATA_W-2:0] mag_c;
   logic              mag_valid;
   logic [DATA_W-2:0] mag;
   logic [DATA_W-2:0] level_q;
   logic [LED_W-1:0]  led_c;
   logic [LED_W-1:0]  led_q;

   assign accept   = i_valid && ready_q;
   assign neg_data = ~i_data + DATA_ONE;
   assign o_ready  = ready_q;
   assign o_led    = led_q;

   // Ready goes high on the first edge after reset and never drops again.
   always_ff @(posedge i_clk) begin
      if (i_reset) ready_q <= 1'b0;
      else         ready_q <= 1'b1;
   end

   // Absolute value; -2^(DATA_W-1) has no positive twin so it clips to max.
   always_comb begin
      mag_c = i_data[DATA_W-2:0];
      if (i_data[DATA_W-1]) begin
         if (i_data[DATA_W-2:0] == '0) mag_c = '1;
         else                          mag_c = neg_data[DATA_W-2:0];
      end
   end

   // Magnitude stage: registers the accepted sample's magnitude.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mag_valid <= 1'b0;
         mag       <= '0;
      end else begin
         mag_valid <= accept;
         if (accept) mag <= mag_c;
      end
   end

`ifdef FXP_LED_PEAK_HOLD_EN
   typedef enum logic [1:0] {
      TRACK = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } state_t;

   localparam int CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);
   localparam logic [DATA_W-2:0] STEP       = (DATA_W-1)'(DECAY_STEP);

   state_t            state_q, state_n;
   logic [DATA_W-2:0] level_n;
   logic [CNT_W-1:0]  hold_q, hold_n;
   logic [CNT_W-1:0]  decay_q, decay_n;
   logic              new_peak;

   assign new_peak = mag_valid && (mag >= level_q) && (mag != '0);

   // State register: FSM state, displayed level and both timers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= TRACK;
         level_q <= '0;
         hold_q  <= '0;
         decay_q <= '0;
      end else begin
         state_q <= state_n;
         level_q <= level_n;
         hold_q  <= hold_n;
         decay_q <= decay_n;
      end
   end

   // Next state: a new peak beats any hold expiry or decay tick that lands on the same edge.
   always_comb begin
      state_n = state_q;
      level_n = level_q;
      hold_n  = hold_q;
      decay_n = decay_q;
      if (new_peak) begin
         state_n = HOLD;
         level_n = mag;
         hold_n  = HOLD_LOAD;
      end else begin
         case (state_q)
            TRACK: ;
            HOLD: begin
               if (hold_q == '0) begin
                  state_n = DECAY;
                  decay_n = DECAY_LOAD;
               end else begin
                  hold_n = hold_q - CNT_ONE;
               end
            end
            DECAY: begin
               if (decay_q == '0) begin
                  decay_n = DECAY_LOAD;
                  if (level_q > STEP) begin
                     level_n = level_q - STEP;
                  end else begin
                     level_n = '0;
                     state_n = TRACK;
                  end
               end else begin
                  decay_n = decay_q - CNT_ONE;
               end
            end
            default: state_n = TRACK;
         endcase
      end
   end

   // Outputs: level and debug state straight from the registers.
   always_comb begin
      o_level = level_q;
      o_state = state_q;
   end
`else
   // Timing parameters only matter to the peak-hold build; an empty block
   // keeps them referenced so both builds share one parameter list.
   if (HOLD_CYCLES < 0 || DECAY_CYCLES < 0 || DECAY_STEP < 0) begin : g_unused_timing
   end

   // Level follows each accepted magnitude and holds between samples.
   always_ff @(posedge i_clk) begin
      if (i_reset)        level_q <= '0;
      else if (mag_valid) level_q <= mag;
   end

   // Outputs: level from its register, FSM absent so state reads TRACK.
   always_comb begin
      o_level = level_q;
      o_state = 2'd0;
   end
`endif

   // LED k lights when the level exceeds floor(k * 2^(DATA_W-1) / LED_W).
   for (genvar k = 0; k < LED_W; k++) begin : g_thr
      localparam logic [DATA_W-1:0] THR = DATA_W'((k * (2 ** (DATA_W - 1))) / LED_W);
      assign led_c[k] = {1'b0, level_q} > THR;
   end

   // LED register: bar trails the displayed level by one clock.
   always_ff @(posedge i_clk) begin
      if (i_reset) led_q <= '0;
      else         led_q <= led_c;
   end

endmodule
